fp8_accumulator: RTL and testbench

- Downstream consumer of the FP8 multiplier products (S EEE MMMM, bias 3). Sums a variable-length stream of products, delimited by in_last, in an exact signed fixed-point register.
- Converts the total back to FP8 and presents it on a valid/ready output.
- Forms the accumulate half of the dot-product / MAC datapath.

---
 rtl/fp8_accumulator.sv | 205 ++++++++++++++++++++
 tb/tb_fp8_accumulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp8_accumulator.sv
// Sums a last-delimited stream of FP8 (S EEE MMMM, bias 3) products in a saturating
// signed fixed-point register (6 fractional bits) and returns the total as FP8.
module fp8_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CONV  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             inf_seen_r, inf_seen_nxt_s;
  logic             inf_sign_r, inf_sign_nxt_s;
  logic             in_ready_r, in_ready_nxt_s;
  logic [7:0]       out_data_r, out_data_nxt_s;
  logic             out_valid_r, out_valid_nxt_s;
  logic [CNT_W-1:0] out_count_r, out_count_nxt_s;
  logic             out_ovf_r, out_ovf_nxt_s;
  logic [8:0]       conv_s;

  // Magnitude of a finite FP8 code in units of 2^-6; infinity codes return zero.
  function automatic logic [9:0] decode_mag(input logic [6:0] em);
    logic [9:0] mag;
    case (em[6:4])
      3'd0:    mag = {6'd0, em[3:0]};
      3'd7:    mag = 10'd0;
      default: mag = {5'd0, 1'b1, em[3:0]} << (em[6:4] - 3'd1);
    endcase
    return mag;
  endfunction

  // Add or subtract a magnitude, clamping to the signed range instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [9:0] m, input logic neg);
    logic [ACC_W:0]   ext;
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] res;
    ext = {{(ACC_W-9){1'b0}}, m};
    if (neg) begin
      wide = {a[ACC_W-1], a} - ext;
    end else begin
      wide = {a[ACC_W-1], a} + ext;
    end
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      if (wide[ACC_W]) begin
        res = ACC_MIN;
      end else begin
        res = ACC_MAX;
      end
    end else begin
      res = wide[ACC_W-1:0];
    end
    return res;
  endfunction

  // Fixed point back to FP8, truncating toward zero; returns {ovf, data}.
  function automatic logic [8:0] convert(input logic [ACC_W-1:0] a,
                                         input logic inf_seen, input logic inf_sign);
    logic [ACC_W-1:0] mag;
    logic [9:0]       sh;
    logic [8:0]       res;
    int               p;
    mag = a[ACC_W-1] ? (~a + {{(ACC_W-1){1'b0}}, 1'b1}) : a;
    p = 0;
    for (int i = 0; i < 10; i++) begin
      if (mag[i]) begin
        p = i;
      end else begin
        p = p;
      end
    end
    if (inf_seen) begin
      res = {1'b1, inf_sign, 7'h70};
    end else if (mag[ACC_W-1:10] != '0) begin
      res = {1'b1, a[ACC_W-1], 7'h70};
    end else if (mag == '0) begin
      res = 9'h000;
    end else if (p >= 4) begin
      sh  = mag[9:0] >> (p - 4);
      res = {1'b0, a[ACC_W-1], 3'(p - 3), sh[3:0]};
    end else begin
      res = {1'b0, a[ACC_W-1], 3'd0, mag[3:0]};
    end
    return res;
  endfunction

  assign conv_s = convert(acc_r, inf_seen_r, inf_sign_r);

  // Next-state, accumulate and output-register logic.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    count_nxt_s     = count_r;
    inf_seen_nxt_s  = inf_seen_r;
    inf_sign_nxt_s  = inf_sign_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    out_count_nxt_s = out_count_r;
    out_ovf_nxt_s   = out_ovf_r;
    case (state_r)
      ACCUM: begin
        if (in_valid && in_ready_r) begin
          if (in_data[6:4] == 3'd7) begin
            inf_seen_nxt_s = 1'b1;
            if (!inf_seen_r) begin
              inf_sign_nxt_s = in_data[7];
            end else begin
              inf_sign_nxt_s = inf_sign_r;
            end
          end else begin
            acc_nxt_s = sat_add(acc_r, decode_mag(in_data[6:0]), in_data[7]);
          end
          if (count_r == {CNT_W{1'b1}}) begin
            count_nxt_s = count_r;
          end else begin
            count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (in_last) begin
            state_nxt_s = CONV;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      CONV: begin
        out_ovf_nxt_s   = conv_s[8];
        out_data_nxt_s  = conv_s[7:0];
        out_count_nxt_s = count_r;
        out_valid_nxt_s = 1'b1;
        state_nxt_s     = HOLD;
      end
      HOLD: begin
        if (out_valid_r && out_ready) begin
          acc_nxt_s       = '0;
          count_nxt_s     = '0;
          inf_seen_nxt_s  = 1'b0;
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = ACCUM;
      end
    endcase
    in_ready_nxt_s = (state_nxt_s == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ACCUM;
      acc_r       <= '0;
      count_r     <= '0;
      inf_seen_r  <= 1'b0;
      inf_sign_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      out_count_r <= '0;
      out_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      count_r     <= count_nxt_s;
      inf_seen_r  <= inf_seen_nxt_s;
      inf_sign_r  <= inf_sign_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_count_r <= out_count_nxt_s;
      out_ovf_r   <= out_ovf_nxt_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_count = out_count_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_fp8_accumulator.sv
// Randomized and directed bench for fp8_accumulator against a real-value reference model.
module tb_fp8_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_count;
  logic       out_ovf;

  fp8_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: exact sum in units of 2^-6, infinity tracking, term count.
  int         m_sum;
  bit         m_inf;
  bit         m_isign;
  int         m_cnt;
  logic [7:0] sq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Real value of a finite code, times 64.
  function automatic int fp8_units(input logic [7:0] b);
    int e;
    int m;
    e = int'(b[6:4]);
    m = int'(b[3:0]);
    if (e == 0) return m;                        // mant/16 * 2^-2 * 64
    return ((16 + m) * 64 * (1 << e)) / 128;     // (1+mant/16) * 2^(e-3) * 64
  endfunction

  task automatic model_reset();
    m_sum = 0; m_inf = 1'b0; m_isign = 1'b0; m_cnt = 0;
  endtask

  task automatic model_add(input logic [7:0] b);
    if (b[6:4] == 3'd7) begin
      if (!m_inf) m_isign = b[7];
      m_inf = 1'b1;
    end else begin
      m_sum = b[7] ? m_sum - fp8_units(b) : m_sum + fp8_units(b);
      if (m_sum > 32767) m_sum = 32767;
      if (m_sum < -32768) m_sum = -32768;
    end
    if (m_cnt < 255) m_cnt++;
  endtask

  // Expected {ovf, data}: largest finite code whose value does not exceed |sum|.
  function automatic logic [8:0] model_expect();
    int         a;
    bit         s;
    logic [7:0] best;
    if (m_inf) return {1'b1, m_isign, 7'h70};
    s = (m_sum < 0);
    a = s ? -m_sum : m_sum;
    if (a >= 1024) return {1'b1, s, 7'h70};
    if (a == 0) return 9'h000;
    best = 8'h00;
    for (int c = 0; c < 112; c++) begin
      if (fp8_units(8'(c)) <= a) best = 8'(c);
    end
    return {1'b0, s, best[6:0]};
  endfunction

  task automatic send(input logic [7:0] b, input logic last);
    int i;
    in_data = b; in_last = last; in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 100) begin
      @(posedge clk); #1; i++;
    end
    if (!in_ready) check_eq("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_add(b);
  endtask

  // Sends sq, checks latency and result, holds the output for 'hold' cycles, then releases it.
  task automatic run_stream(input int hold, input string tag);
    logic [8:0] exp_r;
    foreach (sq[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(sq[i], (i == sq.size() - 1));
    end
    exp_r = model_expect();
    check_eq({tag, ".lat_conv"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, ".lat_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, ".data"}, {24'd0, out_data}, {24'd0, exp_r[7:0]});
    check_eq({tag, ".count"}, {24'd0, out_count}, 32'(m_cnt));
    check_eq({tag, ".ovf"}, {31'd0, out_ovf}, {31'd0, exp_r[8]});
    check_eq({tag, ".in_ready_hold"}, {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_last = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
      @(posedge clk); #1;
      check_eq({tag, ".stable"}, {15'd0, out_valid, in_ready, out_data, out_count},
               {15'd0, 1'b1, 1'b0, exp_r[7:0], 8'(m_cnt)});
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".released"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    model_reset();
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.out", {14'd0, out_valid, out_ovf, out_count, out_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset.in_ready", {31'd0, in_ready}, 32'd1);

    sq = '{8'h38, 8'h38};        run_stream(5, "add_1p5");
    sq = '{8'h38, 8'hB0};        run_stream(0, "sub_half");
    sq = '{8'h38, 8'hB8};        run_stream(0, "cancel_zero");
    sq = '{8'h0F, 8'h01};        run_stream(1, "sub_carry");
    sq = '{8'h01};               run_stream(0, "single_sub");
    sq = '{8'h5F};               run_stream(0, "single_5f");
    sq = '{8'h7A};               run_stream(0, "single_inf");
    sq = '{8'h6F, 8'h6F};        run_stream(0, "mag_ovf");
    sq = '{8'hF0, 8'h70, 8'h38}; run_stream(2, "inf_first_sign");

    sq = '{};
    for (int i = 0; i < 40; i++) sq.push_back(8'h6F);
    for (int i = 0; i < 33; i++) sq.push_back(8'hEF);
    run_stream(0, "sat_pos");
    sq = '{};
    for (int i = 0; i < 40; i++) sq.push_back(8'hEF);
    for (int i = 0; i < 33; i++) sq.push_back(8'h6F);
    run_stream(0, "sat_neg");
    sq = '{};
    for (int i = 0; i < 300; i++) sq.push_back(8'h00);
    run_stream(0, "count_sat");

    send(8'h38, 1'b0);
    send(8'h38, 1'b0);
    rst = 1'b1;
    #2;
    check_eq("midrst.out", {14'd0, out_valid, out_ovf, out_count, out_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    sq = '{8'h30};               run_stream(0, "after_rst");

    for (int t = 0; t < 40; t++) begin
      sq = '{};
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        b = 8'($urandom);
        if (b[6:4] == 3'd7 && $urandom_range(0, 3) != 0) b[6:4] = 3'($urandom_range(0, 6));
        sq.push_back(b);
      end
      run_stream(int'($urandom_range(0, 3)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
